// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control-bundle layout,
// ALU operation codes and immediate formats.
package id_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int CTRL_W           = 11;
    localparam int CTRL_REG_WRITE   = 0;
    localparam int CTRL_MEM_READ    = 1;
    localparam int CTRL_MEM_WRITE   = 2;
    localparam int CTRL_BRANCH      = 3;
    localparam int CTRL_JUMP        = 4;
    localparam int CTRL_ALU_SRC_IMM = 5;
    localparam int CTRL_MEM_TO_REG  = 6;
    localparam int CTRL_ALU_OP_LSB  = 7;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // 32-bit sign-correct immediate; callers widen it to XLEN with a signed cast.
    function automatic logic [31:0] imm32(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] r;
        case (fmt)
            IMM_I:   r = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   r = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   r = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   r = {inst[31:12], 12'h000};
            IMM_J:   r = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// NREGS x XLEN register file, two read ports and one write port; x0 is hardwired to zero.
// With ID_BYPASS_EN defined, a same-cycle write is forwarded to the read ports.
module id_regfile
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [NREGS];

    // Storage: cleared in one edge on reset, x0 never written.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= {XLEN{1'b0}};
            end
        end else if (wen && (waddr != {AW{1'b0}})) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports with optional write-through.
    always_comb begin
        rdata1 = {XLEN{1'b0}};
        rdata2 = {XLEN{1'b0}};
        if (raddr1 != {AW{1'b0}}) begin
`ifdef ID_BYPASS_EN
            rdata1 = (wen && (waddr == raddr1)) ? wdata : regs[raddr1];
`else
            rdata1 = regs[raddr1];
`endif
        end else begin
            rdata1 = {XLEN{1'b0}};
        end
        if (raddr2 != {AW{1'b0}}) begin
`ifdef ID_BYPASS_EN
            rdata2 = (wen && (waddr == raddr2)) ? wdata : regs[raddr2];
`else
            rdata2 = regs[raddr2];
`endif
        end else begin
            rdata2 = {XLEN{1'b0}};
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with ID/EX register, valid/ready handshake, flush and load-use stall.
// Optional feature macro: ID_BYPASS_EN (regfile write-through in the accept cycle).
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   pc,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_controls,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_branch_addr,
    output logic [AW-1:0]     out_rd,
    output logic [AW-1:0]     out_rs1,
    output logic [AW-1:0]     out_rs2,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_illegal
);

    localparam logic [4:0] MAX_REG = 5'(NREGS - 1);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd_f, rs1_f, rs2_f;
    logic              use_rd, use_rs1, use_rs2, bad_enc, illegal;
    logic [3:0]        alu_op;
    imm_fmt_e          fmt;
    logic [CTRL_W-1:0] controls;
    logic [AW-1:0]     rd_idx, rs1_idx, rs2_idx;
    logic [XLEN-1:0]   imm, rs1_val, rs2_val, branch_addr, jalr_sum;
    logic              hazard, accept;

    assign opcode = inst[6:0];
    assign rd_f   = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1_f  = inst[19:15];
    assign rs2_f  = inst[24:20];
    assign funct7 = inst[31:25];

    // Main decoder: register usage, immediate format, ALU op and encoding legality.
    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        bad_enc = 1'b0;
        alu_op  = ALU_ADD;
        fmt     = IMM_NONE;
        case (opcode)
            OPC_LUI:   begin use_rd = 1'b1; fmt = IMM_U; alu_op = ALU_LUI; end
            OPC_AUIPC: begin use_rd = 1'b1; fmt = IMM_U; end
            OPC_JAL:   begin use_rd = 1'b1; fmt = IMM_J; end
            OPC_JALR: begin
                use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I;
                bad_enc = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_B;
                case (funct3)
                    3'b000, 3'b001: alu_op = ALU_SUB;
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        bad_enc = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I;
                bad_enc = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_S;
                bad_enc = (funct3[2] == 1'b1) || (funct3 == 3'b011);
            end
            OPC_OP_IMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin alu_op = ALU_SLL; bad_enc = (funct7 != 7'h00); end
                    3'b101: begin
                        alu_op  = funct7[5] ? ALU_SRA : ALU_SRL;
                        bad_enc = (funct7 != 7'h00) && (funct7 != 7'h20);
                    end
                    default: bad_enc = 1'b1;
                endcase
            end
            OPC_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                bad_enc = (funct7 != 7'h00) && (funct7 != 7'h20);
                case (funct3)
                    3'b000: alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b101: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b001: begin alu_op = ALU_SLL;  bad_enc = (funct7 != 7'h00); end
                    3'b010: begin alu_op = ALU_SLT;  bad_enc = (funct7 != 7'h00); end
                    3'b011: begin alu_op = ALU_SLTU; bad_enc = (funct7 != 7'h00); end
                    3'b100: begin alu_op = ALU_XOR;  bad_enc = (funct7 != 7'h00); end
                    3'b110: begin alu_op = ALU_OR;   bad_enc = (funct7 != 7'h00); end
                    3'b111: begin alu_op = ALU_AND;  bad_enc = (funct7 != 7'h00); end
                    default: bad_enc = 1'b1;
                endcase
            end
            default: bad_enc = 1'b1;
        endcase
    end

    assign illegal = bad_enc
                   || (use_rd  && (rd_f  > MAX_REG))
                   || (use_rs1 && (rs1_f > MAX_REG))
                   || (use_rs2 && (rs2_f > MAX_REG));

    assign rd_idx  = (use_rd  && !illegal) ? rd_f[AW-1:0]  : {AW{1'b0}};
    assign rs1_idx = (use_rs1 && !illegal) ? rs1_f[AW-1:0] : {AW{1'b0}};
    assign rs2_idx = (use_rs2 && !illegal) ? rs2_f[AW-1:0] : {AW{1'b0}};

    // Control bundle; an illegal instruction carries no side effects downstream.
    always_comb begin
        controls = {CTRL_W{1'b0}};
        if (!illegal) begin
            controls[CTRL_REG_WRITE]   = use_rd;
            controls[CTRL_MEM_READ]    = (opcode == OPC_LOAD);
            controls[CTRL_MEM_WRITE]   = (opcode == OPC_STORE);
            controls[CTRL_BRANCH]      = (opcode == OPC_BRANCH);
            controls[CTRL_JUMP]        = (opcode == OPC_JAL) || (opcode == OPC_JALR);
            controls[CTRL_ALU_SRC_IMM] = (fmt == IMM_I) || (fmt == IMM_S) || (fmt == IMM_U);
            controls[CTRL_MEM_TO_REG]  = (opcode == OPC_LOAD);
            controls[CTRL_ALU_OP_LSB +: 4] = alu_op;
        end else begin
            controls = {CTRL_W{1'b0}};
        end
    end

    assign imm      = XLEN'($signed(imm32(inst, fmt)));
    assign jalr_sum = rs1_val + imm;

    // Target address; JALR clears bit 0 of the sum.
    always_comb begin
        case (opcode)
            OPC_BRANCH, OPC_JAL: branch_addr = pc + imm;
            OPC_JALR:            branch_addr = {jalr_sum[XLEN-1:1], 1'b0};
            default:             branch_addr = {XLEN{1'b0}};
        endcase
    end

    id_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .raddr1 (rs1_idx),
        .raddr2 (rs2_idx),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .wen    (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    // Load-use: the value in a load's rd is not available until after MEM.
    assign hazard = out_valid && out_controls[CTRL_MEM_READ] && (out_rd != {AW{1'b0}})
                  && (((out_rd == rs1_idx) && use_rs1) || ((out_rd == rs2_idx) && use_rs2));
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // ID/EX register: flush beats accept; a transfer without accept leaves a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_controls    <= {CTRL_W{1'b0}};
            out_rs1_val     <= {XLEN{1'b0}};
            out_rs2_val     <= {XLEN{1'b0}};
            out_imm         <= {XLEN{1'b0}};
            out_branch_addr <= {XLEN{1'b0}};
            out_rd          <= {AW{1'b0}};
            out_rs1         <= {AW{1'b0}};
            out_rs2         <= {AW{1'b0}};
            out_pc          <= {XLEN{1'b0}};
            out_illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_controls    <= controls;
            out_rs1_val     <= rs1_val;
            out_rs2_val     <= rs2_val;
            out_imm         <= (fmt == IMM_NONE) ? {XLEN{1'b0}} : imm;
            out_branch_addr <= branch_addr;
            out_rd          <= rd_idx;
            out_rs1         <= rs1_idx;
            out_rs2         <= rs2_idx;
            out_pc          <= pc;
            out_illegal     <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe (XLEN=32, NREGS=32).
module tb_id_stage_pipe;

    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, flush, wb_en, out_valid, out_ready, out_illegal;
    logic [31:0] inst, pc, wb_data, out_rs1_val, out_rs2_val, out_imm, out_branch_addr, out_pc;
    logic [4:0]  wb_addr, out_rd, out_rs1, out_rs2;
    logic [10:0] out_controls;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    id_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_controls(out_controls), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_branch_addr(out_branch_addr), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; inst = 32'h0; pc = 32'h0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_ctrl", 64'(out_controls), 64'd0);
        chk("reset_rd", 64'(out_rd), 64'd0);

        // LUI x1,0xA
        inst = 32'h0000A0B7; pc = 32'h0000_0100; in_valid = 1'b1;
        #1 chk("lui_in_ready", 64'(in_ready), 64'd1);
        tick(); in_valid = 1'b0;
        chk("lui_valid", 64'(out_valid), 64'd1);
        chk("lui_rd", 64'(out_rd), 64'd1);
        chk("lui_imm", 64'(out_imm), 64'h0000_A000);
        chk("lui_regwr", 64'(out_controls[0]), 64'd1);
        chk("lui_srcimm", 64'(out_controls[5]), 64'd1);
        chk("lui_illegal", 64'(out_illegal), 64'd0);
        chk("lui_pc", 64'(out_pc), 64'h100);

        // wb x2=0x1234, then ADD x1,x2,x3
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h1234;
        tick(); wb_en = 1'b0;
        chk("bubble_after_lui", 64'(out_valid), 64'd0);
        inst = 32'h003100B3; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("add_rs1_val", 64'(out_rs1_val), 64'h1234);
        chk("add_rs2_val", 64'(out_rs2_val), 64'h0);
        chk("add_ctrl", 64'(out_controls), 64'h001);
        chk("add_rs_idx", 64'({out_rs1, out_rs2}), 64'({5'd2, 5'd3}));
        chk("add_imm", 64'(out_imm), 64'h0);

        // Same-cycle wb x2=0x55 with ADDI x1,x2,8
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h55;
        inst = 32'h00810093; in_valid = 1'b1;
        tick(); wb_en = 1'b0; in_valid = 1'b0;
`ifdef ID_BYPASS_EN
        chk("addi_bypass_rs1", 64'(out_rs1_val), 64'h55);
`else
        chk("addi_prewrite_rs1", 64'(out_rs1_val), 64'h1234);
`endif
        chk("addi_imm", 64'(out_imm), 64'd8);

        // LW x1,8(x2) then dependent ADD x3,x1,x1
        inst = 32'h00812083; in_valid = 1'b1;
        tick();
        chk("lw_memread", 64'(out_controls[1]), 64'd1);
        chk("lw_rs1_val", 64'(out_rs1_val), 64'h55);
        inst = 32'h001081B3;
        #1 chk("loaduse_stall", 64'(in_ready), 64'd0);
        tick();
        chk("loaduse_bubble", 64'(out_valid), 64'd0);
        chk("loaduse_release", 64'(in_ready), 64'd1);
        tick(); in_valid = 1'b0;
        chk("dep_add_valid", 64'(out_valid), 64'd1);
        chk("dep_add_idx", 64'({out_rd, out_rs1, out_rs2}), 64'({5'd3, 5'd1, 5'd1}));
        chk("dep_add_rs1_val", 64'(out_rs1_val), 64'h0);

        // Backpressure: ADDI x5,x0,7 waits while EX holds
        out_ready = 1'b0; inst = 32'h00700293; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
            chk("bp_hold", 64'({out_valid, out_rd, out_rs1}), 64'({1'b1, 5'd3, 5'd1}));
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
        tick(); in_valid = 1'b0;
        chk("bp_next_rd", 64'(out_rd), 64'd5);
        chk("bp_next_imm", 64'(out_imm), 64'd7);

        // Flush with a valid input
        flush = 1'b1; inst = 32'h0000A0B7; in_valid = 1'b1;
        #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick(); flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        tick();
        chk("flush_dropped", 64'(out_valid), 64'd0);

        // x0 write ignored
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        tick(); wb_en = 1'b0;
        inst = 32'h000000B3; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("x0_rs1_val", 64'(out_rs1_val), 64'h0);
        chk("x0_rs2_val", 64'(out_rs2_val), 64'h0);

        // JAL x1,16 at pc 0x200
        inst = 32'h010000EF; pc = 32'h0000_0200; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("jal_target", 64'(out_branch_addr), 64'h210);
        chk("jal_ctrl", 64'(out_controls), 64'h011);

        // Unsupported opcode
        inst = 32'h0000007F; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("illegal_flag", 64'(out_illegal), 64'd1);
        chk("illegal_ctrl", 64'(out_controls), 64'd0);
        chk("illegal_valid", 64'(out_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
